// File: rtl/mc_datapath.sv
// Multi-cycle CPU datapath: register file, PC, instruction latch, MAR/MDR, ALU and
// flags, sequenced by a three-state FSM that takes one command per valid/ready handshake.
module mc_datapath #(
    parameter int XLEN   = 32,
    parameter int NREG   = 16,
    parameter int ADDR_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [2:0]              cmd_op_i,
    input  logic [2:0]              alu_op_i,
    input  logic [$clog2(NREG)-1:0] rd_i,
    input  logic [$clog2(NREG)-1:0] rs1_i,
    input  logic [$clog2(NREG)-1:0] rs2_i,
    input  logic                    sel_b_imm_i,
    input  logic [XLEN-1:0]         imm_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [XLEN-1:0]         mem_wdata_o,
    input  logic [XLEN-1:0]         mem_rdata_i,
    input  logic                    mem_ready_i,
    output logic [ADDR_W-1:0]       pc_o,
    output logic [2:0]              alu_flag_o,
    output logic                    retire_o,
    input  logic [$clog2(NREG)-1:0] dbg_addr_i,
    output logic [XLEN-1:0]         dbg_data_o
);
    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(XLEN);

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_JMP   = 3'b011;
    localparam logic [2:0] OP_BRZ   = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cmdOp_q, aluOp_q;
    logic [RW-1:0]     rd_q, rs1_q, rs2_q;
    logic              selBImm_q;
    logic [XLEN-1:0]   imm_q;
    logic [ADDR_W-1:0] pc_q, pc_d, memAddr_q, memAddr_d;
    logic [XLEN-1:0]   memData_q, memData_d;
    logic [2:0]        flags_q, flags_d;
    logic [XLEN-1:0]   regs_q [NREG];

    logic              isMemOp, memDone, regWe, aluCarry;
    logic [XLEN-1:0]   regWdata, opA, opB, aluRes;

    assign isMemOp = (cmdOp_q == OP_LOAD) || (cmdOp_q == OP_STORE);
    assign memDone = (state_q == MEM) && mem_ready_i;
    assign opA     = regs_q[rs1_q];
    assign opB     = selBImm_q ? imm_q : regs_q[rs2_q];

    // Carry doubles as the SUB borrow; shifts only honour the low log2(XLEN) bits of B.
    always_comb begin
        aluRes   = '0;
        aluCarry = 1'b0;
        case (aluOp_q)
            3'b000:  {aluCarry, aluRes} = {1'b0, opA} + {1'b0, opB};
            3'b001:  begin
                aluRes   = opA - opB;
                aluCarry = opA < opB;
            end
            3'b010:  aluRes = opA & opB;
            3'b011:  aluRes = opA | opB;
            3'b100:  aluRes = opA ^ opB;
            3'b101:  aluRes = opA << opB[SW-1:0];
            3'b110:  aluRes = opA >> opB[SW-1:0];
            default: aluRes = opB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid_i) state_d = EXEC;
            EXEC:    state_d = isMemOp ? MEM : IDLE;
            MEM:     if (mem_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and memory strobes are forced low for the whole time reset is held.
    always_comb begin
        cmd_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        retire_o    = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE:    cmd_ready_o = 1'b1;
                EXEC:    retire_o = !isMemOp;
                MEM:     begin
                    mem_req_o = 1'b1;
                    mem_we_o  = (cmdOp_q == OP_STORE);
                    retire_o  = mem_ready_i;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pc_d      = pc_q;
        flags_d   = flags_q;
        memAddr_d = memAddr_q;
        memData_d = memData_q;
        regWe     = 1'b0;
        regWdata  = aluRes;
        if (state_q == EXEC) begin
            case (cmdOp_q)
                OP_ALU:   begin
                    regWe   = 1'b1;
                    flags_d = {aluCarry, aluRes[XLEN-1], aluRes == '0};
                    pc_d    = pc_q + ADDR_W'(1);
                end
                OP_LOAD, OP_STORE: begin
                    memAddr_d = ADDR_W'(opA + imm_q);
                    memData_d = regs_q[rs2_q];
                end
                OP_JMP:   pc_d = imm_q[ADDR_W-1:0];
                OP_BRZ:   pc_d = flags_q[0] ? pc_q + imm_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
                default:  pc_d = pc_q + ADDR_W'(1);
            endcase
        end else if (memDone) begin
            pc_d     = pc_q + ADDR_W'(1);
            regWe    = (cmdOp_q == OP_LOAD);
            regWdata = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= '0;
            flags_q   <= '0;
            memAddr_q <= '0;
            memData_q <= '0;
            cmdOp_q   <= '0;
            aluOp_q   <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            selBImm_q <= 1'b0;
            imm_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            flags_q   <= flags_d;
            memAddr_q <= memAddr_d;
            memData_q <= memData_d;
            if (state_q == IDLE && cmd_valid_i) begin
                cmdOp_q   <= cmd_op_i;
                aluOp_q   <= alu_op_i;
                rd_q      <= rd_i;
                rs1_q     <= rs1_i;
                rs2_q     <= rs2_i;
                selBImm_q <= sel_b_imm_i;
                imm_q     <= imm_i;
            end
        end
    end

    // r0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (regWe && rd_q != '0) begin
            regs_q[rd_q] <= regWdata;
        end
    end

    assign dbg_data_o  = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memData_q;
    assign pc_o        = pc_q;
    assign alu_flag_o  = flags_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a table of single-cycle commands with hand-computed
// results, then hand sequences for stores/loads, held valid, and reset during MEM.
module tb_mc_datapath;
    localparam int XLEN   = 32;
    localparam int NREG   = 16;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [2:0]        cmd_op_i, alu_op_i;
    logic [3:0]        rd_i, rs1_i, rs2_i, dbg_addr_i;
    logic              sel_b_imm_i;
    logic [XLEN-1:0]   imm_i, mem_wdata_o, mem_rdata_i, dbg_data_o;
    logic              mem_req_o, mem_we_o, mem_ready_i, retire_o;
    logic [ADDR_W-1:0] mem_addr_o, pc_o;
    logic [2:0]        alu_flag_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  aluOp;
        logic [3:0]  rd, rs1, rs2;
        logic        selImm;
        logic [31:0] imm;
        logic [3:0]  dbgAddr;
        logic [31:0] expDbg;
        logic [15:0] expPc;
        logic [2:0]  expFlags;
    } vec_t;

    vec_t vecs [18];

    mc_datapath #(.XLEN(XLEN), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .alu_op_i(alu_op_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .sel_b_imm_i(sel_b_imm_i), .imm_i(imm_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .pc_o(pc_o), .alu_flag_o(alu_flag_o), .retire_o(retire_o),
        .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [2:0] op, input logic [2:0] aluOp,
                                   input logic [3:0] rd, input logic [3:0] rs1,
                                   input logic [3:0] rs2, input logic selImm,
                                   input logic [31:0] imm, input logic [3:0] dbgAddr,
                                   input logic [31:0] expDbg, input logic [15:0] expPc,
                                   input logic [2:0] expFlags);
        vec_t v;
        v.op = op; v.aluOp = aluOp; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.selImm = selImm; v.imm = imm; v.dbgAddr = dbgAddr; v.expDbg = expDbg;
        v.expPc = expPc; v.expFlags = expFlags;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReg(input string name, input logic [3:0] addr, input logic [31:0] exp);
        dbg_addr_i = addr;
        #1;
        checkOutput(name, dbg_data_o, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        cmd_op_i    = v.op;
        alu_op_i    = v.aluOp;
        rd_i        = v.rd;
        rs1_i       = v.rs1;
        rs2_i       = v.rs2;
        sel_b_imm_i = v.selImm;
        imm_i       = v.imm;
        cmd_valid_i = 1'b1;
    endtask

    task automatic runSingle(input vec_t v, input string tag);
        applyStimulus(v);
        #1;
        checkOutput({tag, "_ready"}, cmd_ready_o, 1);
        tick();
        cmd_valid_i = 1'b0;
        checkOutput({tag, "_retire"}, retire_o, 1);
        checkOutput({tag, "_busy"}, cmd_ready_o, 0);
        tick();
        checkOutput({tag, "_retire_low"}, retire_o, 0);
        checkOutput({tag, "_pc"}, pc_o, v.expPc);
        checkOutput({tag, "_flags"}, alu_flag_o, v.expFlags);
        checkReg({tag, "_reg"}, v.dbgAddr, v.expDbg);
    endtask

    task automatic runLoad(input logic [3:0] rd, input logic [3:0] rs1, input logic [31:0] imm,
                           input logic [31:0] rdata, input logic [15:0] expAddr,
                           input logic [31:0] expReg, input logic [15:0] expPc, input string tag);
        applyStimulus(mkVec(3'b001, 3'b000, rd, rs1, 4'd0, 1'b0, imm, 4'd0, 0, 0, 0));
        tick();
        cmd_valid_i = 1'b0;
        checkOutput({tag, "_exec_req"}, mem_req_o, 0);
        checkOutput({tag, "_exec_retire"}, retire_o, 0);
        tick();
        checkOutput({tag, "_req"}, mem_req_o, 1);
        checkOutput({tag, "_we"}, mem_we_o, 0);
        checkOutput({tag, "_addr"}, mem_addr_o, expAddr);
        mem_rdata_i = rdata;
        mem_ready_i = 1'b1;
        #1;
        checkOutput({tag, "_retire"}, retire_o, 1);
        tick();
        mem_ready_i = 1'b0;
        checkOutput({tag, "_idle_req"}, mem_req_o, 0);
        checkOutput({tag, "_idle_ready"}, cmd_ready_o, 1);
        checkOutput({tag, "_pc"}, pc_o, expPc);
        checkOutput({tag, "_flags"}, alu_flag_o, 3'b001);
        checkReg({tag, "_reg"}, rd, expReg);
    endtask

    initial begin
        // op, aluOp, rd, rs1, rs2, selImm, imm, dbgAddr, expDbg, expPc, expFlags
        vecs[0]  = mkVec(3'b000, 3'b000, 4'd1,  4'd0, 4'd0, 1'b1, 32'd5,        4'd1,  32'd5,        16'd1,      3'b000);
        vecs[1]  = mkVec(3'b000, 3'b001, 4'd2,  4'd1, 4'd1, 1'b0, 32'd0,        4'd2,  32'd0,        16'd2,      3'b001);
        vecs[2]  = mkVec(3'b000, 3'b000, 4'd4,  4'd0, 4'd0, 1'b1, 32'd3,        4'd4,  32'd3,        16'd3,      3'b000);
        vecs[3]  = mkVec(3'b000, 3'b001, 4'd5,  4'd4, 4'd1, 1'b0, 32'd0,        4'd5,  32'hFFFFFFFE, 16'd4,      3'b110);
        vecs[4]  = mkVec(3'b000, 3'b111, 4'd6,  4'd0, 4'd0, 1'b1, 32'hFFFFFFFF, 4'd6,  32'hFFFFFFFF, 16'd5,      3'b010);
        vecs[5]  = mkVec(3'b000, 3'b000, 4'd7,  4'd6, 4'd0, 1'b1, 32'd1,        4'd7,  32'd0,        16'd6,      3'b101);
        vecs[6]  = mkVec(3'b100, 3'b000, 4'd0,  4'd0, 4'd0, 1'b0, 32'h0000FFFE, 4'd7,  32'd0,        16'd4,      3'b101);
        vecs[7]  = mkVec(3'b000, 3'b010, 4'd8,  4'd6, 4'd0, 1'b1, 32'h000000F0, 4'd8,  32'h000000F0, 16'd5,      3'b000);
        vecs[8]  = mkVec(3'b100, 3'b000, 4'd0,  4'd0, 4'd0, 1'b0, 32'h00000100, 4'd8,  32'h000000F0, 16'd6,      3'b000);
        vecs[9]  = mkVec(3'b000, 3'b011, 4'd9,  4'd8, 4'd1, 1'b0, 32'd0,        4'd9,  32'h000000F5, 16'd7,      3'b000);
        vecs[10] = mkVec(3'b000, 3'b100, 4'd10, 4'd9, 4'd0, 1'b1, 32'h000000FF, 4'd10, 32'h0000000A, 16'd8,      3'b000);
        vecs[11] = mkVec(3'b000, 3'b101, 4'd11, 4'd1, 4'd0, 1'b1, 32'h00000024, 4'd11, 32'h00000050, 16'd9,      3'b000);
        vecs[12] = mkVec(3'b000, 3'b110, 4'd12, 4'd6, 4'd0, 1'b1, 32'd31,       4'd12, 32'd1,        16'd10,     3'b000);
        vecs[13] = mkVec(3'b000, 3'b000, 4'd0,  4'd0, 4'd0, 1'b1, 32'd7,        4'd0,  32'd0,        16'd11,     3'b000);
        vecs[14] = mkVec(3'b101, 3'b000, 4'd0,  4'd0, 4'd0, 1'b0, 32'd0,        4'd1,  32'd5,        16'd12,     3'b000);
        vecs[15] = mkVec(3'b011, 3'b000, 4'd0,  4'd0, 4'd0, 1'b0, 32'hABCD1234, 4'd1,  32'd5,        16'h1234,   3'b000);
        vecs[16] = mkVec(3'b000, 3'b110, 4'd13, 4'd1, 4'd0, 1'b1, 32'd3,        4'd13, 32'd0,        16'h1235,   3'b001);
        vecs[17] = mkVec(3'b011, 3'b000, 4'd0,  4'd0, 4'd0, 1'b0, 32'd0,        4'd13, 32'd0,        16'd0,      3'b001);

        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i = '0; alu_op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        sel_b_imm_i = 1'b0; imm_i = '0; mem_rdata_i = '0; mem_ready_i = 1'b0; dbg_addr_i = '0;
        tick();
        tick();
        checkOutput("rst_ready", cmd_ready_o, 0);
        checkOutput("rst_req", mem_req_o, 0);
        checkOutput("rst_we", mem_we_o, 0);
        checkOutput("rst_retire", retire_o, 0);
        rst_i = 1'b0;
        #1;
        checkOutput("post_rst_ready", cmd_ready_o, 1);
        checkOutput("post_rst_pc", pc_o, 0);
        checkOutput("post_rst_flags", alu_flag_o, 0);
        checkOutput("post_rst_addr", mem_addr_o, 0);
        checkOutput("post_rst_wdata", mem_wdata_o, 0);

        for (int i = 0; i < 18; i++) runSingle(vecs[i], $sformatf("v%0d", i));

        // STORE r1 -> [r0+0x10] with ready four cycles late, while a different command stays valid.
        applyStimulus(mkVec(3'b010, 3'b000, 4'd0, 4'd0, 4'd1, 1'b0, 32'h10, 4'd0, 0, 0, 0));
        tick();
        applyStimulus(mkVec(3'b000, 3'b000, 4'd14, 4'd0, 4'd0, 1'b1, 32'd9, 4'd0, 0, 0, 0));
        checkOutput("st_exec_req", mem_req_o, 0);
        checkOutput("st_exec_retire", retire_o, 0);
        checkOutput("st_exec_ready", cmd_ready_o, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) mem_ready_i = 1'b1;
            #1;
            checkOutput($sformatf("st_req%0d", k), mem_req_o, 1);
            checkOutput($sformatf("st_we%0d", k), mem_we_o, 1);
            checkOutput($sformatf("st_addr%0d", k), mem_addr_o, 16'h0010);
            checkOutput($sformatf("st_wdata%0d", k), mem_wdata_o, 32'd5);
            checkOutput($sformatf("st_busy%0d", k), cmd_ready_o, 0);
            checkOutput($sformatf("st_retire%0d", k), retire_o, (k == 5) ? 1 : 0);
            checkOutput($sformatf("st_pc%0d", k), pc_o, 0);
        end
        tick();
        mem_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        checkOutput("st_done_req", mem_req_o, 0);
        checkOutput("st_done_pc", pc_o, 1);
        checkOutput("st_done_flags", alu_flag_o, 3'b001);
        checkReg("st_no_second_accept", 4'd14, 0);

        runLoad(4'd3, 4'd0, 32'h10, 32'd5, 16'h0010, 32'd5, 16'd2, "ld_r3");
        runLoad(4'd0, 4'd6, 32'h21, 32'hDEAD, 16'h0020, 32'd0, 16'd3, "ld_r0");

        runSingle(mkVec(3'b100, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0000FFFE, 4'd3, 32'd5, 16'd1, 3'b001),
                  "brz_wrap");

        // Reset arrives in MEM together with ready: the load must not land.
        applyStimulus(mkVec(3'b001, 3'b000, 4'd1, 4'd0, 4'd0, 1'b0, 32'h30, 4'd0, 0, 0, 0));
        tick();
        cmd_valid_i = 1'b0;
        tick();
        checkOutput("rm_req", mem_req_o, 1);
        checkOutput("rm_addr", mem_addr_o, 16'h0030);
        rst_i = 1'b1;
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h77;
        #1;
        checkOutput("rm_rst_req", mem_req_o, 0);
        checkOutput("rm_rst_ready", cmd_ready_o, 0);
        checkOutput("rm_rst_retire", retire_o, 0);
        tick();
        rst_i = 1'b0;
        mem_ready_i = 1'b0;
        #1;
        checkOutput("rm_after_req", mem_req_o, 0);
        checkOutput("rm_after_ready", cmd_ready_o, 1);
        checkOutput("rm_after_pc", pc_o, 0);
        checkOutput("rm_after_flags", alu_flag_o, 0);
        checkReg("rm_r1", 4'd1, 0);
        checkReg("rm_r3", 4'd3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Parametrised multi-cycle CPU datapath: register file, program counter, instruction latch, memory address/data registers, ALU and flag register, sequenced by an internal FSM. The control unit issues one decoded command at a time over a valid/ready handshake. The block executes it and drives a request/ready memory port for loads and stores. Widths, register count and address width are generic so the same datapath serves the 16- and 32-bit cores.

## Interface

- XLEN, 32, data/register width (≥8)
- NREG, 16, register count (power of 2, ≥2); r0 reads zero, writes ignored
- ADDR_W, 16, memory address and PC width (≤XLEN)
- Decided: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  block accepts a command (IDLE and not in reset)
- cmd_op_i  in  3  000 ALU, 001 LOAD, 010 STORE, 011 JMP, 100 BRZ, others NOP
- alu_op_i  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 PASS_B
- rd_i, rs1_i, rs2_i  in  $clog2(NREG) each  register addresses
- sel_b_imm_i  in  1  ALU operand B: 0 = rs2, 1 = imm_i
- imm_i  in  XLEN  immediate
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  ADDR_W  word address
- mem_wdata_o  out  XLEN  store data
- mem_rdata_i  in  XLEN  load data, valid when mem_ready_i=1
- mem_ready_i  in  1  access complete
- pc_o  out  ADDR_W  program counter
- alu_flag_o  out  3  {carry, negative, zero} flag register
- retire_o  out  1  high in the final cycle of each command
- dbg_addr_i  in  $clog2(NREG)  debug read address
- dbg_data_o  out  XLEN  combinational register read (r0 → 0)

## Operation

- FSM states are IDLE, EXEC and MEM.
- IDLE: cmd_ready_o=1. When cmd_valid_i=1, latch all command fields into the instruction latch and go to EXEC.
- EXEC (one cycle):
  - ALU: rd ← rs1 op B; flags updated; PC+1; retire; → IDLE.
  - LOAD/STORE: MAR ← (rs1+imm)[ADDR_W-1:0]; MDR ← rs2; → MEM. PC and flags unchanged here.
  - JMP: PC ← imm[ADDR_W-1:0]; retire; → IDLE.
  - BRZ: if zero flag, PC ← PC+imm[ADDR_W-1:0], else PC+1; retire; → IDLE.
  - NOP: PC+1; retire; → IDLE.
- MEM: mem_req_o=1. mem_we_o, mem_addr_o=MAR and mem_wdata_o=MDR are held stable until mem_ready_i=1. On that cycle: LOAD writes rd ← mem_rdata_i; PC+1; retire; → IDLE. The block waits indefinitely for mem_ready_i.
- ALU arithmetic is modulo 2^XLEN.
  - carry = ADD carry-out, or SUB borrow (rs1 < B unsigned); 0 for all other ops.
  - negative = result MSB; zero = (result == 0).
  - Shift amount is B[$clog2(XLEN)-1:0].
- Flags change only on ALU commands. LOAD, STORE, JMP and BRZ leave them unchanged.
- PC and address arithmetic wrap modulo 2^ADDR_W.
- Writes to r0 are dropped. A LOAD to r0 still performs the memory access.

## Timing

- Reset values: state IDLE, PC=0, all registers 0, flags 000, MAR/MDR 0. mem_req_o=0, mem_we_o=0, retire_o=0, cmd_ready_o=0 while rst_i=1.
- cmd_ready_o=1 in the first cycle after rst_i falls.
- Latency from accept edge to retire:
  - ALU/JMP/BRZ/NOP: retire_o in the next cycle (EXEC); result visible after that edge. Throughput is 1 command per 2 cycles.
  - LOAD/STORE: EXEC cycle, then mem_req_o from cycle 2; retire in the cycle mem_ready_i=1. Minimum 3 cycles accept-to-IDLE.
- mem_ready_i outside MEM is ignored. cmd_valid_i outside IDLE is ignored and the command is not accepted.
- Reset mid-command: the next edge returns to IDLE, and mem_req_o is low in the following cycle. No register, PC or flag write from the aborted command.
- dbg_data_o reflects a register write from the edge onward (no bypass before the edge).

## Test plan

- Reset, then ALU ADD imm: r1 ← r0+5 → r1=5, PC=1, flags=000, retire_o one cycle.
- SUB r2=r1-rs(r1=5): zero=1, carry=0. SUB 3-5 (XLEN=32) → 0xFFFFFFFE, negative=1, carry=1. ADD 0xFFFFFFFF+1 → 0, zero=1, carry=1.
- STORE r1 to rs1=r0, imm=0x10, mem_ready_i delayed 4 cycles → mem_req_o high 5 cycles, addr=0x10, we=1, wdata=5 held stable; PC+1 on the ready cycle. Then LOAD r3 from 0x10 → r3=5.
- BRZ with zero=1, PC=3, imm=0xFFFE (ADDR_W=16) → PC=1 (wrap). BRZ with zero=0 → PC=PC+1. JMP imm=0x1234 → PC=0x1234.
- Write r0 via ALU (result 7) → dbg read r0=0. cmd_valid_i held in EXEC/MEM → no second accept.
- rst_i asserted during MEM before mem_ready_i → mem_req_o low after one cycle; LOAD target register unchanged; PC=0.
